oddr_serializer: RTL and testbench



---
 rtl/oddr_serializer.sv | 128 ++++++++++++
 tb/tb_oddr_serializer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oddr_serializer.sv
// N:2 gearbox in front of a per-pin ODDR. It takes one RATIO*WIDTH word per handshake and
// emits one (d1, d2) beat pair per clock, with frame tracking, idle fill and underrun flagging.
//
// Handshake: a word transfers on any rising edge where s_valid & s_ready. s_ready depends
// only on rst and internal state, never on s_valid, and s_data/s_last are ignored otherwise.
module oddr_serializer #(
  parameter int              WIDTH      = 1,
  parameter int              RATIO      = 4,
  parameter int              MSB_FIRST  = 0,
  parameter logic [WIDTH-1:0] IDLE_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RATIO*WIDTH-1:0] s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [WIDTH-1:0]       d1,
  output logic [WIDTH-1:0]       d2,
  output logic                   q_valid,
  output logic                   in_frame,
  output logic                   underrun,
  input  logic                   underrun_clr,
  output logic                   dbg_state
);

  localparam int PAIRS = RATIO / 2;
  localparam int KW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(PAIRS - 1);

  if (((RATIO % 2) != 0) || (RATIO < 2)) begin : g_bad_ratio
    $error("oddr_serializer: RATIO must be even and at least 2");
  end

  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  state_t                 r_state, w_state_nxt;
  logic [KW-1:0]          r_k, w_k_nxt;
  logic [RATIO*WIDTH-1:0] r_word, w_src;
  logic                   r_last;
  logic [WIDTH-1:0]       r_d1, r_d2;
  logic                   r_q_valid, r_in_frame, r_underrun;
  logic                   w_accept, w_end_word, w_set_ur;

  function automatic logic [WIDTH-1:0] beat(input logic [RATIO*WIDTH-1:0] w, input int j);
    int                     idx;
    logic [RATIO*WIDTH-1:0] t;
    idx = (MSB_FIRST != 0) ? (RATIO - 1 - j) : j;
    t   = w >> (idx * WIDTH);
    return t[WIDTH-1:0];
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_end_word  = (r_state == ST_SHIFT) && (r_k == K_LAST);
    s_ready     = !rst && ((r_state == ST_IDLE) || w_end_word);
    w_accept    = s_ready && s_valid;
    if (w_accept) begin
      w_state_nxt = ST_SHIFT;
      w_k_nxt     = '0;
    end else if (w_end_word) begin
      w_state_nxt = ST_IDLE;
    end else if (r_state == ST_SHIFT) begin
      w_k_nxt = r_k + KW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
    end
  end

  // The output registers are loaded with the pair that belongs to the next state, so a word
  // accepted on this edge shows pair 0 straight away in the following cycle.
  assign w_src    = w_accept ? s_data : r_word;
  // A frame starves when a non-final word runs out and nothing replaces it on that edge.
  assign w_set_ur = r_in_frame && w_end_word && !r_last && !w_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word     <= '0;
      r_last     <= 1'b0;
      r_d1       <= IDLE_VALUE;
      r_d2       <= IDLE_VALUE;
      r_q_valid  <= 1'b0;
      r_in_frame <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_word <= s_data;
        r_last <= s_last;
      end
      if (w_state_nxt == ST_SHIFT) begin
        r_d1      <= beat(w_src, 2 * int'(w_k_nxt));
        r_d2      <= beat(w_src, 2 * int'(w_k_nxt) + 1);
        r_q_valid <= 1'b1;
      end else begin
        r_d1      <= IDLE_VALUE;
        r_d2      <= IDLE_VALUE;
        r_q_valid <= 1'b0;
      end
      if (w_accept && !s_last) begin
        r_in_frame <= 1'b1;
      end else if (w_end_word && r_last) begin
        r_in_frame <= 1'b0;
      end
      if (w_set_ur) begin
        r_underrun <= 1'b1;
      end else if (underrun_clr) begin
        r_underrun <= 1'b0;
      end
    end
  end

  assign d1        = r_d1;
  assign d2        = r_d2;
  assign q_valid   = r_q_valid;
  assign in_frame  = r_in_frame;
  assign underrun  = r_underrun;
  assign dbg_state = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_oddr_serializer.sv
// Bench for oddr_serializer: a queue-based model of the beat stream checked every cycle on a
// WIDTH=4/RATIO=4 instance, plus directed literal checks and a WIDTH=8/RATIO=2 MSB-first instance.
module tb_oddr_serializer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0, s_last = 1'b0, underrun_clr = 1'b0;
  logic        s_ready, q_valid, in_frame, underrun, dbg_state;
  logic [3:0]  d1, d2;

  logic        rst2 = 1'b1, s2_valid = 1'b0;
  logic [15:0] s2_data = 16'hA55A;
  logic        s2_ready, q2_valid, in2_frame, under2run, dbg2_state;
  logic [7:0]  d2_1, d2_2;

  oddr_serializer #(.WIDTH(4), .RATIO(4), .MSB_FIRST(0), .IDLE_VALUE(4'h0)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .d1(d1), .d2(d2), .q_valid(q_valid), .in_frame(in_frame),
    .underrun(underrun), .underrun_clr(underrun_clr), .dbg_state(dbg_state));

  oddr_serializer #(.WIDTH(8), .RATIO(2), .MSB_FIRST(1), .IDLE_VALUE(8'h3C)) dut2 (
    .clk(clk), .rst(rst2), .s_data(s2_data), .s_valid(s2_valid), .s_last(1'b1),
    .s_ready(s2_ready), .d1(d2_1), .d2(d2_2), .q_valid(q2_valid), .in_frame(in2_frame),
    .underrun(under2run), .underrun_clr(1'b0), .dbg_state(dbg2_state));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (main instance) ----------------
  typedef struct packed {
    logic [3:0] d1;
    logic [3:0] d2;
    logic       eow;
    logic       eof;
  } pair_t;

  localparam int PAIRS = 2;
  pair_t pend[$];
  pair_t cur;
  bit    cur_v = 0, m_in = 0, m_ur = 0, model_on = 0;
  logic [31:0] exp_q[$];

  function automatic logic [3:0] mbeat(input logic [15:0] w, input int j);
    logic [15:0] t;
    t = w >> (4 * j);
    return t[3:0];
  endfunction

  always @(posedge clk) begin
    bit acc, end_w, set_ur;
    acc = !rst && s_valid && (pend.size() == 0);
    if (rst) begin
      pend.delete();
      cur_v = 0; m_in = 0; m_ur = 0; model_on = 1;
    end else if (model_on) begin
      end_w  = cur_v && cur.eow;
      set_ur = m_in && end_w && !cur.eof && !acc;
      if (acc && !s_last) m_in = 1;
      else if (end_w && cur.eof) m_in = 0;
      if (set_ur) m_ur = 1;
      else if (underrun_clr) m_ur = 0;
      if (acc) begin
        for (int k = 0; k < PAIRS; k++)
          pend.push_back('{mbeat(s_data, 2*k), mbeat(s_data, 2*k+1), k == PAIRS-1, s_last});
      end
      if (pend.size() > 0) begin
        cur = pend.pop_front();
        cur_v = 1;
      end else begin
        cur_v = 0;
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (model_on) begin
      exp_q.delete();
      exp_q.push_back(cur_v ? {28'd0, cur.d1} : 32'd0);
      exp_q.push_back(cur_v ? {28'd0, cur.d2} : 32'd0);
      exp_q.push_back({31'd0, cur_v});
      exp_q.push_back({31'd0, m_in});
      exp_q.push_back({31'd0, m_ur});
      exp_q.push_back({31'd0, (!rst && pend.size() == 0)});
      check("m_d1",       {28'd0, d1},       exp_q.pop_front());
      check("m_d2",       {28'd0, d2},       exp_q.pop_front());
      check("m_q_valid",  {31'd0, q_valid},  exp_q.pop_front());
      check("m_in_frame", {31'd0, in_frame}, exp_q.pop_front());
      check("m_underrun", {31'd0, underrun}, exp_q.pop_front());
      check("m_s_ready",  {31'd0, s_ready},  exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a word and holds it until it transfers; returns one step into the cycle after.
  task automatic send_word(input logic [15:0] w, input logic last);
    bit done;
    done = 0;
    s_data = w; s_last = last; s_valid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      if (s_ready) done = 1;
      tick();
    end
    s_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout: word %0h not accepted within 20 cycles", w);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit prev_ready;
    repeat (3) tick();
    check("rst_d1", {28'd0, d1}, 32'h0);
    check("rst_q_valid", {31'd0, q_valid}, 32'h0);
    check("rst_s_ready", {31'd0, s_ready}, 32'h0);
    check("rst_in_frame", {31'd0, in_frame}, 32'h0);
    check("rst_underrun", {31'd0, underrun}, 32'h0);
    check("r2_rst_d1", {24'd0, d2_1}, 32'h3C);
    check("r2_rst_d2", {24'd0, d2_2}, 32'h3C);
    check("r2_rst_s_ready", {31'd0, s2_ready}, 32'h0);
    rst = 1'b0; rst2 = 1'b0; s2_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("r2_d1", {24'd0, d2_1}, 32'hA5);
      check("r2_d2", {24'd0, d2_2}, 32'h5A);
      check("r2_q_valid", {31'd0, q2_valid}, 32'h1);
      check("r2_s_ready", {31'd0, s2_ready}, 32'h1);
    end
    s2_valid = 1'b0;

    // single-word frame
    send_word(16'hDCBA, 1'b1);
    check("t1_p0_d1", {28'd0, d1}, 32'hA);
    check("t1_p0_d2", {28'd0, d2}, 32'hB);
    check("t1_p0_qv", {31'd0, q_valid}, 32'h1);
    tick();
    check("t1_p1_d1", {28'd0, d1}, 32'hC);
    check("t1_p1_d2", {28'd0, d2}, 32'hD);
    tick();
    check("t1_idle_d1", {28'd0, d1}, 32'h0);
    check("t1_idle_qv", {31'd0, q_valid}, 32'h0);
    check("t1_in_frame", {31'd0, in_frame}, 32'h0);
    check("t1_underrun", {31'd0, underrun}, 32'h0);

    // back-to-back words
    send_word(16'h3210, 1'b0);
    check("t2_p0_d1", {28'd0, d1}, 32'h0);
    check("t2_p0_d2", {28'd0, d2}, 32'h1);
    check("t2_p0_ready", {31'd0, s_ready}, 32'h0);
    send_word(16'h7654, 1'b1);
    check("t2_p2_d1", {28'd0, d1}, 32'h4);
    check("t2_p2_d2", {28'd0, d2}, 32'h5);
    check("t2_p2_ready", {31'd0, s_ready}, 32'h0);
    tick();
    check("t2_p3_d1", {28'd0, d1}, 32'h6);
    check("t2_p3_d2", {28'd0, d2}, 32'h7);
    tick();
    check("t2_in_frame", {31'd0, in_frame}, 32'h0);
    check("t2_underrun", {31'd0, underrun}, 32'h0);

    // starved frame
    send_word(16'h1111, 1'b0);
    tick();
    tick();
    check("t3_underrun", {31'd0, underrun}, 32'h1);
    check("t3_gap_qv", {31'd0, q_valid}, 32'h0);
    check("t3_gap_d1", {28'd0, d1}, 32'h0);
    check("t3_gap_in_frame", {31'd0, in_frame}, 32'h1);
    tick();
    send_word(16'h2222, 1'b1);
    tick();
    check("t3_in_frame_tail", {31'd0, in_frame}, 32'h1);
    tick();
    check("t3_in_frame_end", {31'd0, in_frame}, 32'h0);
    check("t3_underrun_sticky", {31'd0, underrun}, 32'h1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("t3_underrun_clr", {31'd0, underrun}, 32'h0);

    // stalled word while another shifts
    send_word(16'h1234, 1'b0);
    send_word(16'hBEEF, 1'b1);
    check("t4_p0_d1", {28'd0, d1}, 32'hF);
    check("t4_p0_d2", {28'd0, d2}, 32'hE);
    tick();
    check("t4_p1_d1", {28'd0, d1}, 32'hE);
    check("t4_p1_d2", {28'd0, d2}, 32'hB);
    check("t4_underrun", {31'd0, underrun}, 32'h0);
    tick();

    // reset mid-word
    send_word(16'hDCBA, 1'b1);
    check("t5_p0_d1", {28'd0, d1}, 32'hA);
    rst = 1'b1;
    tick();
    check("t5_rst_d1", {28'd0, d1}, 32'h0);
    check("t5_rst_d2", {28'd0, d2}, 32'h0);
    check("t5_rst_qv", {31'd0, q_valid}, 32'h0);
    check("t5_rst_ready", {31'd0, s_ready}, 32'h0);
    rst = 1'b0;
    send_word(16'h0F0F, 1'b1);
    check("t5_p0_d1", {28'd0, d1}, 32'hF);
    check("t5_p0_d2", {28'd0, d2}, 32'h0);
    tick();
    check("t5_p1_d1", {28'd0, d1}, 32'hF);
    check("t5_p1_d2", {28'd0, d2}, 32'h0);
    tick();
    check("t5_idle_qv", {31'd0, q_valid}, 32'h0);

    // randomized traffic; an offered word is held until it transfers
    for (int i = 0; i < 600; i++) begin
      prev_ready = s_ready;
      tick();
      if (!s_valid || prev_ready || rst) begin
        s_valid = ($urandom_range(0, 9) < 6);
        s_data  = 16'($urandom);
        s_last  = ($urandom_range(0, 2) == 0);
      end
      underrun_clr = ($urandom_range(0, 19) == 0);
      rst          = ($urandom_range(0, 149) == 0);
    end
    rst = 1'b0; s_valid = 1'b0; underrun_clr = 1'b0;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
